// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory controller.
package imem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // NOP encoding returned for fetches beyond the populated range
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Program-load and fetch bus between host/fetch logic and instr_mem_ctrl.
interface instr_mem_ctrl_if
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128
);
    localparam int IDX_W = idx_width(DEPTH);

    logic                  clear;
    logic                  ready;
    logic                  prog_we;
    logic [IDX_W-1:0]      prog_addr;
    logic [DATA_WIDTH-1:0] prog_data;
    logic                  fetch_req;
    logic [31:0]           fetch_addr;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  fetch_misaligned;
    logic                  fetch_oob;

    modport master (
        output clear, prog_we, prog_addr, prog_data, fetch_req, fetch_addr,
        input  ready, fetch_valid, instruction, fetch_misaligned, fetch_oob
    );

    modport slave (
        input  clear, prog_we, prog_addr, prog_data, fetch_req, fetch_addr,
        output ready, fetch_valid, instruction, fetch_misaligned, fetch_oob
    );

endinterface

// File: rtl/imem_array.sv
// Simple dual-port 1W/1R synchronous RAM, read-first, registered read with enable.
// Latency 1; no backpressure.
module imem_array
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    localparam int IDX_W     = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Both updates are non-blocking, so a same-address read sees the old word
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: clear sweep FSM, program write port, registered fetch.
// Fetch latency 1 cycle, one request per cycle; requests and writes ignored while sweeping.
module instr_mem_ctrl
    import imem_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 128,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0,
    parameter logic [DATA_WIDTH-1:0] OOB_WORD   = DATA_WIDTH'(NOP_WORD)
) (
    input  logic              clk,
    input  logic              reset,
    instr_mem_ctrl_if.slave   bus
);

    localparam int          IDX_W     = idx_width(DEPTH);
    localparam int          BYTE_SH   = $clog2(DATA_WIDTH / 8);
    localparam logic [31:0] BYTE_MASK = (32'd1 << BYTE_SH) - 32'd1;

    state_t                r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_sweep_idx, w_sweep_nxt;

    logic                  w_ready;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_rdata;

    logic [31:0]           w_idx32;
    logic                  w_oob;
    logic                  w_mis;
    logic                  w_fetch_acc;

    logic                  r_fetch_valid;
    logic                  r_misaligned;
    logic                  r_oob;
    logic                  r_have_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_CLEAR;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_sweep_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep_idx;
        if (bus.clear) begin
            w_state_nxt = ST_CLEAR;
            w_sweep_nxt = '0;
        end else if (r_state == ST_CLEAR) begin
            if (r_sweep_idx == IDX_W'(DEPTH - 1)) begin
                w_state_nxt = ST_RUN;
                w_sweep_nxt = '0;
            end else begin
                w_sweep_nxt = r_sweep_idx + 1'b1;
            end
        end
    end

    // Single write port is shared: sweep owns it in CLEAR, the loader in RUN
    always_comb begin
        w_ready     = 1'b0;
        w_mem_we    = 1'b1;
        w_mem_waddr = r_sweep_idx;
        w_mem_wdata = FILL_WORD;
        if (r_state == ST_RUN) begin
            w_ready     = 1'b1;
            w_mem_we    = bus.prog_we;
            w_mem_waddr = bus.prog_addr;
            w_mem_wdata = bus.prog_data;
        end
    end

    // Full 32-bit range compare so large addresses never alias into the array
    assign w_idx32     = bus.fetch_addr >> BYTE_SH;
    assign w_oob       = (w_idx32 >= 32'(DEPTH));
    assign w_mis       = ((bus.fetch_addr & BYTE_MASK) != 32'd0);
    assign w_fetch_acc = w_ready & bus.fetch_req & ~bus.clear;

    imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_fetch_acc & ~w_oob),
        .i_raddr (w_idx32[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_valid <= 1'b0;
            r_misaligned  <= 1'b0;
            r_oob         <= 1'b0;
            r_have_data   <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_acc;
            if (w_fetch_acc) begin
                r_misaligned <= w_mis;
                r_oob        <= w_oob;
                r_have_data  <= 1'b1;
            end
        end
    end

    // RAM output register is unreset; r_have_data gives a clean zero after reset
    assign bus.instruction      = !r_have_data ? '0 : (r_oob ? OOB_WORD : w_rdata);
    assign bus.ready            = w_ready;
    assign bus.fetch_valid      = r_fetch_valid;
    assign bus.fetch_misaligned = r_misaligned;
    assign bus.fetch_oob        = r_oob;

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised instruction memory for the fetch stage: synchronous word-array storage with a program-load write port and a registered fetch read port using a req/valid handshake.
- Successor to the fixed 32-bit/128-entry instruction store: adds configurable word width and depth, a runtime load port, a hardware clear sweep, and fault reporting for misaligned or out-of-range fetches.
- Sits between the PC/fetch logic and the decode stage; the loader/debug host drives the program port.

Parameters:
DATA_WIDTH, 32, instruction word width in bits; multiple of 8, power of 2 bytes
DEPTH, 128, number of words; power of 2, >= 2
FILL_WORD, 32'h0000_0000, value written to every word by the clear sweep (width DATA_WIDTH)
OOB_WORD, 32'h0000_0013, word returned on an out-of-range fetch (NOP encoding)
Derived localparams: IDX_W = clog2(DEPTH), BYTE_SH = clog2(DATA_WIDTH/8)

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous pulse; restarts the clear sweep
ready  out  1  high when the sweep is complete and the block accepts fetches/writes
prog_we  in  1  program write enable
prog_addr  in  IDX_W  word index for the program write
prog_data  in  DATA_WIDTH  program write data
fetch_req  in  1  fetch request, one per cycle allowed
fetch_addr  in  32  byte address of the instruction
fetch_valid  out  1  response strobe, one cycle
instruction  out  DATA_WIDTH  fetched word
fetch_misaligned  out  1  response flag: fetch_addr[BYTE_SH-1:0] != 0
fetch_oob  out  1  response flag: (fetch_addr >> BYTE_SH) >= DEPTH

Behaviour:
- Reset values (asynchronous on reset=1): state=CLEAR, sweep_idx=0, ready=0, fetch_valid=0, instruction=0, fetch_misaligned=0, fetch_oob=0.
- The array is not reset asynchronously; it is cleared by the sweep.
- FSM states:
  - CLEAR: each cycle writes FILL_WORD to mem[sweep_idx] and increments sweep_idx. At sweep_idx == DEPTH-1, the write occurs and the next state is RUN. Duration is exactly DEPTH cycles after reset deassertion.
  - RUN: ready=1.
  - clear=1 in any state: next state CLEAR, sweep_idx=0, ready=0 next cycle. clear during CLEAR restarts the sweep from 0.
- While in CLEAR: fetch_req and prog_we are ignored (no response, no write); fetch_valid stays 0.
- Program write (RUN, prog_we=1): mem[prog_addr] <= prog_data at the clock edge.
- Fetch (RUN, fetch_req=1): registered; 1-cycle latency. The next cycle carries fetch_valid=1 plus instruction and both flags.
  - idx = fetch_addr >> BYTE_SH, full 32-bit compare against DEPTH.
  - idx < DEPTH: instruction = mem[idx[IDX_W-1:0]], fetch_oob=0.
  - idx >= DEPTH: instruction = OOB_WORD, fetch_oob=1. No wrap-around and no aliasing to entry 0.
  - Misaligned addresses: low bits are ignored for indexing; fetch_misaligned=1; data still returned.
- fetch_req=0 in RUN: next-cycle fetch_valid=0; instruction and flags hold their last values.
- Back-to-back requests: one response per cycle, in order, no bubbles.
- Same-cycle write and fetch to the same index: read-first. The response carries the old word; the new word is visible to fetches issued from the next cycle.
- Same cycle: clear=1 with fetch_req=1 → request dropped, fetch_valid=0 next cycle.
- Reset mid-sweep or mid-fetch: pending response discarded, sweep restarts from 0 after deassertion.

Decomposition:
- Shared package (imem_pkg): state enum {CLEAR, RUN}, the NOP OOB_WORD default constant, and a clog2-based index-width function.
- One natural sub-module: imem_array, a simple dual-port (1W/1R) synchronous read-first RAM parametrised by DATA_WIDTH/DEPTH, so it can map to block RAM. The controller holds the FSM, sweep counter, address decode, and response registers.

Test Plan:
- Reset release, DEPTH=128: ready=0 for exactly 128 cycles, then 1. Fetch of addr 0x0 and 0x1FC returns 0x00000000 with fetch_valid one cycle later and both flags 0.
- Write idx 5 = 0xDEADBEEF, then fetch addr 0x14: instruction=0xDEADBEEF, flags 0. Fetch addr 0x15: same data, fetch_misaligned=1.
- Fetch addr 0x200 (idx 128) and 0xFFFF_FFFC: instruction=0x00000013, fetch_oob=1; entry 0 is not returned.
- Back-to-back fetches 0x0, 0x4, 0x8 (preloaded 0x11, 0x22, 0x33): fetch_valid high 3 consecutive cycles with data 0x11, 0x22, 0x33 in order.
- Same-cycle write idx 3 = 0xAAAA0000 and fetch 0xC (old 0x12345678): response 0x12345678; next fetch 0xC returns 0xAAAA0000.
- Pulse clear mid-RUN with a fetch issued the same cycle: no response, ready=0 for 128 cycles, all words read 0 afterwards. Assert reset at sweep_idx=60: sweep restarts and takes the full 128 cycles.
